// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding and
// the width of the nibble index counter.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder slice; purely combinational, reused once per nibble.
module rca_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] s_o,
  output logic             cout_o
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < NIB_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one rca_4bit slice processes one nibble per clock,
// LSB first, with the carry registered between nibbles. Valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   BUSY  | one nibble added per clock, idx_q selects the nibble
//   DONE  | result presented on sum/cout/ovf until out_ready
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_cout;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;

  always_comb begin
    nib_a = a_q[NIB_W*idx_q +: NIB_W];
    nib_b = b_q[NIB_W*idx_q +: NIB_W];
  end

  rca_4bit u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_cout)
  );

  // Partial sums build up in acc_q so the visible sum only changes when a result completes.
  always_comb begin
    acc_d = acc_q;
    acc_d[NIB_W*idx_q +: NIB_W] = nib_s;
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIB_W-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_q   <= acc_d;
          carry_q <= nib_cout;
          if (idx_q == IDX_LAST) begin
            idx_q       <= '0;
            sum_q       <= acc_d;
            cout_q      <= nib_cout;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
